// File: rtl/pong_pkg.sv
// Shared definitions for the paddle video logic.
//   pad_state_e      : per-channel paddle sequencer state
//   DEF_HEIGHT_LOG2  : default paddle height exponent (16 lines)
//   DEF_SEG_W        : width of the segment index fed to the ball-angle logic
//   FRAME_LINES      : number of visible lines; paddles never draw past it
package pong_pkg;

   typedef enum logic [1:0] {
      PAD_IDLE   = 2'd0,
      PAD_DELAY  = 2'd1,
      PAD_ACTIVE = 2'd2,
      PAD_DONE   = 2'd3
   } pad_state_e;

   localparam int DEF_HEIGHT_LOG2 = 4;
   localparam int DEF_SEG_W       = DEF_HEIGHT_LOG2 - 1;
   localparam int FRAME_LINES     = 256;

endpackage

// File: rtl/paddle_array_if.sv
// Bus between the video timing / player position logic (master) and the
// paddle generator (slave).
//   _hsync, _v256, _attract : active-low timing and mode levels
//   hpos_en                 : per-channel horizontal column window
//   vpos                    : packed vertical positions, channel i at [i*POS_W +: POS_W]
//   seg                     : packed segment index per channel
//   pad                     : per-channel paddle window
//   pad_any                 : OR of all pad bits
interface paddle_array_if
   import pong_pkg::*;
#(
   parameter int NUM_PADDLES = 2,
   parameter int POS_W       = 8,
   parameter int HEIGHT_LOG2 = DEF_HEIGHT_LOG2
);
   localparam int SEG_W = HEIGHT_LOG2 - 1;

   logic                           _hsync;
   logic                           _v256;
   logic                           _attract;
   logic [NUM_PADDLES-1:0]         hpos_en;
   logic [NUM_PADDLES*POS_W-1:0]   vpos;
   logic [NUM_PADDLES*SEG_W-1:0]   seg;
   logic [NUM_PADDLES-1:0]         pad;
   logic                           pad_any;

   modport master (
      output _hsync, _v256, _attract, hpos_en, vpos,
      input  seg, pad, pad_any
   );

   modport slave (
      input  _hsync, _v256, _attract, hpos_en, vpos,
      output seg, pad, pad_any
   );

endinterface

// File: rtl/paddle_channel.sv
// One paddle channel: latches its position at frame start, waits that many
// lines, then opens a 2^HEIGHT_LOG2-line window.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   line_evt_i           : one-cycle pulse at each line start
//   frame_evt_i          : one-cycle pulse at frame start (line 0)
//   v256_ni              : registered _v256 level; low = below line 255
//   attract_ni           : _attract level
//   hpos_en_i            : horizontal column window for this channel
//   vpos_i               : vertical position in lines
//   seg_o                : line-pair index inside the paddle while drawing
//   pad_o                : registered paddle window
//   pad_d_o              : next value of pad_o, for the shared OR in the top
module paddle_channel
   import pong_pkg::*;
#(
   parameter int POS_W        = 8,
   parameter int HEIGHT_LOG2  = DEF_HEIGHT_LOG2,
   parameter int ATTRACT_HIDE = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    line_evt_i,
   input  logic                    frame_evt_i,
   input  logic                    v256_ni,
   input  logic                    attract_ni,
   input  logic                    hpos_en_i,
   input  logic [POS_W-1:0]        vpos_i,
   output logic [HEIGHT_LOG2-2:0]  seg_o,
   output logic                    pad_o,
   output logic                    pad_d_o
);
   localparam int SEG_W = HEIGHT_LOG2 - 1;

   localparam logic [1:0] S_IDLE   = PAD_IDLE;
   localparam logic [1:0] S_DELAY  = PAD_DELAY;
   localparam logic [1:0] S_ACTIVE = PAD_ACTIVE;
   localparam logic [1:0] S_DONE   = PAD_DONE;

   logic [1:0]             state_q,  state_d;
   logic [POS_W-1:0]       shadow_q, shadow_d;
   logic [POS_W-1:0]       dly_q,    dly_d;
   logic [HEIGHT_LOG2-1:0] cnt_q,    cnt_d;
   logic [SEG_W-1:0]       seg_q,    seg_d;
   logic                   pad_q,    pad_d;
   logic                   hide;
   logic                   active_d;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      dly_d    = dly_q;
      cnt_d    = cnt_q;
      if (frame_evt_i) begin
         // A line event landing on the same cycle is dropped: frame start is line 0.
         shadow_d = vpos_i;
         dly_d    = vpos_i;
         cnt_d    = '0;
         state_d  = (vpos_i == '0) ? S_ACTIVE : S_DELAY;
      end else if (!v256_ni) begin
         // Bottom of the visible frame clips the paddle; no wrap into the next frame.
         state_d = S_IDLE;
      end else if (line_evt_i) begin
         case (state_q)
            S_DELAY: begin
               dly_d = dly_q - 1'b1;
               if (dly_q == POS_W'(1)) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   // Outputs are registered from next-state so they line up with the state change.
   assign hide     = (ATTRACT_HIDE != 0) && !attract_ni;
   assign active_d = (state_d == S_ACTIVE);
   assign pad_d    = active_d && hpos_en_i && !hide;
   assign seg_d    = active_d ? cnt_d[HEIGHT_LOG2-1:1] : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         dly_q    <= '0;
         cnt_q    <= '0;
         seg_q    <= '0;
         pad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         dly_q    <= dly_d;
         cnt_q    <= cnt_d;
         seg_q    <= seg_d;
         pad_q    <= pad_d;
      end
   end

   assign seg_o   = seg_q;
   assign pad_o   = pad_q;
   assign pad_d_o = pad_d;

endmodule

// File: rtl/paddle_array.sv
// Paddle window generator for NUM_PADDLES players. Shared edge detectors turn
// _hsync falls into line events and _v256 rises into frame events; each
// channel then runs its own line counter against its latched position.
//   clk     : system clock
//   _reset  : asynchronous active-low reset
//   bus     : paddle_array_if slave (timing/position in, seg/pad/pad_any out)
module paddle_array
   import pong_pkg::*;
#(
   parameter int NUM_PADDLES  = 2,
   parameter int POS_W        = 8,
   parameter int HEIGHT_LOG2  = DEF_HEIGHT_LOG2,
   parameter int ATTRACT_HIDE = 0
) (
   input  logic          clk,
   input  logic          _reset,
   paddle_array_if.slave bus
);
   localparam int SEG_W = HEIGHT_LOG2 - 1;

   logic                         hsync_q, hsync_dly_q;
   logic                         v256_q,  v256_dly_q;
   logic                         line_evt, frame_evt;
   logic                         pad_any_q;
   logic [NUM_PADDLES-1:0]       pad_w, pad_d_w;
   logic [NUM_PADDLES*SEG_W-1:0] seg_w;

   // Edge registers reset high so releasing reset never fakes an edge.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         hsync_q     <= 1'b1;
         hsync_dly_q <= 1'b1;
         v256_q      <= 1'b1;
         v256_dly_q  <= 1'b1;
         pad_any_q   <= 1'b0;
      end else begin
         hsync_q     <= bus._hsync;
         hsync_dly_q <= hsync_q;
         v256_q      <= bus._v256;
         v256_dly_q  <= v256_q;
         pad_any_q   <= |pad_d_w;
      end
   end

   assign line_evt  = hsync_dly_q & ~hsync_q;
   assign frame_evt = v256_q & ~v256_dly_q;

   for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
      paddle_channel #(
         .POS_W        (POS_W),
         .HEIGHT_LOG2  (HEIGHT_LOG2),
         .ATTRACT_HIDE (ATTRACT_HIDE)
      ) u_ch (
         .clk_i       (clk),
         .rst_ni      (_reset),
         .line_evt_i  (line_evt),
         .frame_evt_i (frame_evt),
         .v256_ni     (v256_q),
         .attract_ni  (bus._attract),
         .hpos_en_i   (bus.hpos_en[i]),
         .vpos_i      (bus.vpos[i*POS_W +: POS_W]),
         .seg_o       (seg_w[i*SEG_W +: SEG_W]),
         .pad_o       (pad_w[i]),
         .pad_d_o     (pad_d_w[i])
      );
   end

   assign bus.seg     = seg_w;
   assign bus.pad     = pad_w;
   assign bus.pad_any = pad_any_q;

endmodule

// File: tb/tb_paddle_array.sv
// Bench for paddle_array: two instances (attract hiding on and off) share one
// randomized video timing stream and are compared every clock against a
// line-number/window model of the paddle rules.
module tb_paddle_array;

   localparam int NP       = 2;
   localparam int PW       = 8;
   localparam int HL       = 4;
   localparam int SW       = HL - 1;
   localparam int LINE_CLK = 8;
   localparam int FRAME_LN = 262;
   localparam int NFRAMES  = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic               hsync_n, v256_n, attract_n;
   logic [NP-1:0]      hpos;
   logic [NP*PW-1:0]   vpos;

   paddle_array_if #(.NUM_PADDLES(NP), .POS_W(PW), .HEIGHT_LOG2(HL)) bus_h ();
   paddle_array_if #(.NUM_PADDLES(NP), .POS_W(PW), .HEIGHT_LOG2(HL)) bus_s ();

   assign bus_h._hsync   = hsync_n;
   assign bus_h._v256    = v256_n;
   assign bus_h._attract = attract_n;
   assign bus_h.hpos_en  = hpos;
   assign bus_h.vpos     = vpos;
   assign bus_s._hsync   = hsync_n;
   assign bus_s._v256    = v256_n;
   assign bus_s._attract = attract_n;
   assign bus_s.hpos_en  = hpos;
   assign bus_s.vpos     = vpos;

   paddle_array #(.NUM_PADDLES(NP), .POS_W(PW), .HEIGHT_LOG2(HL), .ATTRACT_HIDE(1)) dut_h (
      .clk    (clk),
      ._reset (rst_n),
      .bus    (bus_h)
   );

   paddle_array #(.NUM_PADDLES(NP), .POS_W(PW), .HEIGHT_LOG2(HL), .ATTRACT_HIDE(0)) dut_s (
      .clk    (clk),
      ._reset (rst_n),
      .bus    (bus_s)
   );

   // What the bench has driven in one cycle, in frame terms.
   typedef struct packed {
      logic              framed;   // a frame start has been seen since reset
      logic              v256;
      logic [15:0]       line;
      logic [NP*PW-1:0]  sh;       // positions captured at frame start
      logic [NP-1:0]     hpos;
      logic              attract;
   } st_t;

   st_t cur, d1, d2;   // d1/d2 = status driven one/two cycles ago

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Paddle i covers lines sh..sh+2^HL-1 of a started frame, clipped at 255.
   function automatic void model_out(input st_t v, input st_t h, input bit hide_en,
                                     output logic [NP-1:0] pad, output logic [NP*SW-1:0] seg);
      pad = '0;
      seg = '0;
      for (int i = 0; i < NP; i++) begin
         int sh;
         int ln;
         sh = int'(v.sh[i*PW +: PW]);
         ln = int'(v.line);
         if (v.framed && v.v256 && ln < 256 && ln >= sh && ln < sh + (1 << HL)) begin
            seg[i*SW +: SW] = SW'((ln - sh) / 2);
            pad[i]          = h.hpos[i] && !(hide_en && !h.attract);
         end
      end
   endfunction

   task automatic sample_and_check();
      logic [NP-1:0]    ep;
      logic [NP*SW-1:0] es;
      @(posedge clk);
      #1;
      model_out(d2, d1, 1'b1, ep, es);
      check("pad_hide",     32'(bus_h.pad),     32'(ep));
      check("seg_hide",     32'(bus_h.seg),     32'(es));
      check("pad_any_hide", 32'(bus_h.pad_any), 32'(|ep));
      model_out(d2, d1, 1'b0, ep, es);
      check("pad_show",     32'(bus_s.pad),     32'(ep));
      check("seg_show",     32'(bus_s.seg),     32'(es));
      check("pad_any_show", 32'(bus_s.pad_any), 32'(|ep));
   endtask

   task automatic drive(input logic hs, input logic vb, input logic att, input logic [NP-1:0] hp);
      logic rise, fall;
      rise      = vb && !v256_n;
      fall      = !hs && hsync_n;
      hsync_n   = hs;
      v256_n    = vb;
      attract_n = att;
      hpos      = hp;
      cur.hpos    = hp;
      cur.attract = att;
      cur.v256    = vb;
      if (rise) begin
         cur.framed = 1'b1;
         cur.line   = '0;
         cur.sh     = vpos;
      end else if (fall && cur.line != 16'hffff) begin
         cur.line = cur.line + 16'd1;
      end
      d2 = d1;
      d1 = cur;
   endtask

   task automatic reset_now();
      rst_n = 1'b0;
      #1;
      check("rst_pad_hide", 32'(bus_h.pad),     32'd0);
      check("rst_seg_hide", 32'(bus_h.seg),     32'd0);
      check("rst_any_hide", 32'(bus_h.pad_any), 32'd0);
      check("rst_pad_show", 32'(bus_s.pad),     32'd0);
      check("rst_seg_show", 32'(bus_s.seg),     32'd0);
      check("rst_any_show", 32'(bus_s.pad_any), 32'd0);
      cur.framed = 1'b0;
      d1.framed  = 1'b0;
      d2.framed  = 1'b0;
   endtask

   function automatic logic [PW-1:0] rand_pos();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return PW'($urandom_range(240, 255));
         default: return PW'($urandom_range(0, 255));
      endcase
   endfunction

   function automatic logic [NP-1:0] rand_hpos();
      logic [NP-1:0] h;
      for (int i = 0; i < NP; i++) h[i] = ($urandom_range(0, 3) != 0);
      return h;
   endfunction

   initial begin
      logic [NP*PW-1:0] nxt;
      logic             coinc;
      logic             att;
      logic             vb;

      cur       = '0;
      d1        = '0;
      d2        = '0;
      rst_n     = 1'b0;
      hsync_n   = 1'b1;
      v256_n    = 1'b0;
      attract_n = 1'b1;
      hpos      = '0;
      vpos      = '0;
      vpos[0 +: PW]  = PW'(100);
      vpos[PW +: PW] = PW'(250);
      nxt       = vpos;
      #1;
      check("reset_pad",     32'(bus_h.pad),     32'd0);
      check("reset_seg",     32'(bus_h.seg),     32'd0);
      check("reset_pad_any", 32'(bus_s.pad_any), 32'd0);

      for (int k = 0; k < 4; k++) begin
         sample_and_check();
         drive(1'b1, 1'b0, 1'b1, rand_hpos());
      end
      rst_n = 1'b1;

      for (int f = 0; f < NFRAMES; f++) begin
         case (f)
            0:       coinc = 1'b1;
            1:       coinc = 1'b0;
            default: coinc = 1'($urandom_range(0, 1));
         endcase
         nxt[PW +: PW] = rand_pos();
         case (f)
            0:       nxt[0 +: PW] = PW'(20);
            1, 2:    nxt[0 +: PW] = PW'(100);
            default: nxt[0 +: PW] = rand_pos();
         endcase
         att = (f != 3);

         for (int ln = 0; ln < FRAME_LN; ln++) begin
            if (f >= 4) att = 1'($urandom_range(0, 1));
            for (int c = 0; c < LINE_CLK; c++) begin
               sample_and_check();
               if (f == 2 && ln == 105 && c == 4) reset_now();
               if (f == 2 && ln == 105 && c == 7) rst_n = 1'b1;
               if (ln == 50 && c == 3) vpos = nxt;
               if (ln == 0)        vb = coinc ? 1'b1 : (c >= 4);
               else if (ln < 256)  vb = 1'b1;
               else                vb = 1'b0;
               drive((c >= 2), vb, att, rand_hpos());
            end
         end
      end

      for (int k = 0; k < 4; k++) begin
         sample_and_check();
         drive(1'b1, 1'b0, 1'b1, rand_hpos());
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
